// File: rtl/set_clock_timekeeper_pkg.sv
// Shared encodings and limits for the set-clock timekeeper.
// The CLOCK_12H_EN build uses HOUR_MAX_12; the default build uses HOUR_MAX_24.
package set_clock_pkg;

    // The state encoding matches the Field output code, so Field is the state itself.
    typedef enum logic [1:0] {
        RUN      = 2'b00,
        SET_HOUR = 2'b01,
        SET_MIN  = 2'b10
    } state_t;

    localparam logic [1:0] FIELD_NONE    = 2'b00;
    localparam logic [1:0] FIELD_HOURS   = 2'b01;
    localparam logic [1:0] FIELD_MINUTES = 2'b10;

    localparam logic [5:0] SEC_MAX     = 6'd59;
    localparam logic [5:0] MIN_MAX     = 6'd59;
    localparam logic [4:0] HOUR_MAX_24 = 5'd23;
    localparam logic [4:0] HOUR_MAX_12 = 5'd12;

    function automatic logic [5:0] wrap_inc6(input logic [5:0] value, input logic [5:0] max);
        return (value == max) ? 6'd0 : value + 6'd1;
    endfunction

    function automatic logic [1:0] field_of(input state_t st);
        case (st)
            SET_HOUR: return FIELD_HOURS;
            SET_MIN:  return FIELD_MINUTES;
            default:  return FIELD_NONE;
        endcase
    endfunction

endpackage

// File: rtl/set_clock_timekeeper_if.sv
// Control inputs and time/status outputs of the set-clock timekeeper.
interface set_clock_timekeeper_if
    import set_clock_pkg::*;
();
    // No valid/ready pairs here: Tick is a one-cycle qualifier that is consumed on the
    // edge it is high, Shot/Inc/Sel are levels, and the outputs are always valid.
    logic       Shot;
    logic       Tick;
    logic       Inc;
    logic       Sel;
    logic [4:0] Hours;
    logic [5:0] Minutes;
    logic [5:0] Seconds;
    logic [1:0] Field;
    logic       Set_Mode;
    logic       PM;
    state_t     dbg_state;

    modport master (
        output Shot, Tick, Inc, Sel,
        input  Hours, Minutes, Seconds, Field, Set_Mode, PM, dbg_state
    );

    modport slave (
        input  Shot, Tick, Inc, Sel,
        output Hours, Minutes, Seconds, Field, Set_Mode, PM, dbg_state
    );

endinterface

// File: rtl/set_clock_timekeeper_edge_detect.sv
// Rising-edge detector: one register of history, rise = current high and last low.
module edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= 1'b0;
        end else begin
            prev <= in;
        end
    end

    assign rise = in & ~prev;

endmodule

// File: rtl/set_clock_timekeeper.sv
// Time-of-day counter with a Shot/Inc/Sel set sequence (RUN -> SET_HOUR -> SET_MIN).
// Define CLOCK_12H_EN for a 1..12 hour range with a PM flag; otherwise 0..23 and PM=0.
module set_clock_timekeeper
    import set_clock_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    set_clock_timekeeper_if.slave  bus
);

    state_t     state;
    logic [4:0] hours;
    logic [5:0] minutes;
    logic [5:0] seconds;

    logic shot_rise;
    logic inc_rise;
    logic sel_rise;

    edge_detect u_shot_edge (.clk(clk), .reset(reset), .in(bus.Shot), .rise(shot_rise));
    edge_detect u_inc_edge  (.clk(clk), .reset(reset), .in(bus.Inc),  .rise(inc_rise));
    edge_detect u_sel_edge  (.clk(clk), .reset(reset), .in(bus.Sel),  .rise(sel_rise));

    // Hours advance either by the full seconds+minutes carry in RUN or by an Inc edge
    // while editing hours; a Shot edge or a Sel edge in the same cycle suppresses it.
    logic run_carry_hour;
    logic set_inc_hour;
    logic hour_adv;
    logic [4:0] hour_next;
    logic [4:0] hour_reset_val;

    assign run_carry_hour = (state == RUN) && bus.Tick &&
                            (seconds == SEC_MAX) && (minutes == MIN_MAX);
    assign set_inc_hour   = (state == SET_HOUR) && bus.Shot && !sel_rise && inc_rise;
    assign hour_adv       = !shot_rise && (run_carry_hour || set_inc_hour);

`ifdef CLOCK_12H_EN
    logic pm_q;

    assign hour_reset_val = HOUR_MAX_12;
    assign hour_next      = (hours == HOUR_MAX_12) ? 5'd1 : hours + 5'd1;

    // PM flips on the 11 -> 12 step, whether it came from the carry or from Inc.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pm_q <= 1'b0;
        end else if (hour_adv && (hours == HOUR_MAX_12 - 5'd1)) begin
            pm_q <= ~pm_q;
        end
    end

    assign bus.PM = pm_q;
`else
    assign hour_reset_val = 5'd0;
    assign hour_next      = (hours == HOUR_MAX_24) ? 5'd0 : hours + 5'd1;
    assign bus.PM         = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= RUN;
            hours   <= hour_reset_val;
            minutes <= 6'd0;
            seconds <= 6'd0;
        end else if (shot_rise) begin
            // Entering the set sequence wins over any coincident Tick, Inc or Sel.
            state   <= SET_HOUR;
            seconds <= 6'd0;
        end else begin
            if (hour_adv) begin
                hours <= hour_next;
            end
            case (state)
                RUN: begin
                    if (bus.Tick) begin
                        seconds <= wrap_inc6(seconds, SEC_MAX);
                        if (seconds == SEC_MAX) begin
                            minutes <= wrap_inc6(minutes, MIN_MAX);
                        end
                    end
                end
                SET_HOUR: begin
                    if (!bus.Shot) begin
                        state <= RUN;
                    end else if (sel_rise) begin
                        state <= SET_MIN;
                    end
                end
                SET_MIN: begin
                    if (!bus.Shot) begin
                        state <= RUN;
                    end else if (sel_rise) begin
                        state <= RUN;
                    end else if (inc_rise) begin
                        minutes <= wrap_inc6(minutes, MIN_MAX);
                    end
                end
                default: begin
                    state <= RUN;
                end
            endcase
        end
    end

    assign bus.Hours     = hours;
    assign bus.Minutes   = minutes;
    assign bus.Seconds   = seconds;
    assign bus.Field     = field_of(state);
    assign bus.Set_Mode  = (state != RUN);
    assign bus.dbg_state = state;

endmodule

// File: tb/tb_set_clock_timekeeper.sv
// Bench for set_clock_timekeeper: reference model feeds an expected queue that a monitor
// drains after each edge; scenario tasks add targeted checks. Honors CLOCK_12H_EN.
module tb_set_clock_timekeeper;
    import set_clock_pkg::*;

    localparam int W = 21;

`ifdef CLOCK_12H_EN
    localparam int RST_H     = 12;
    localparam int N_HINC    = 11;
    localparam int PRE_H     = 11;
    localparam int ROLL_H    = 12;
    localparam int ROLL_PM   = 1;
    localparam int SET_EXP_H = 1;
`else
    localparam int RST_H     = 0;
    localparam int N_HINC    = 23;
    localparam int PRE_H     = 23;
    localparam int ROLL_H    = 0;
    localparam int ROLL_PM   = 0;
    localparam int SET_EXP_H = 13;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    set_clock_timekeeper_if bus();

    set_clock_timekeeper dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- reference model + scoreboard ----------------
    int   m_st, m_h, m_m, m_s;
    logic m_pm;
    logic p_shot, p_inc, p_sel;
    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_fail = 0;

    task automatic model_reset();
        m_st = 0; m_h = RST_H; m_m = 0; m_s = 0; m_pm = 1'b0;
        p_shot = 1'b0; p_inc = 1'b0; p_sel = 1'b0;
    endtask

    task automatic model_hour_inc();
`ifdef CLOCK_12H_EN
        if (m_h == 11) m_pm = ~m_pm;
        m_h = (m_h == 12) ? 1 : m_h + 1;
`else
        m_h = (m_h + 1) % 24;
`endif
    endtask

    task automatic model_step(input logic shot, input logic tick, input logic inc, input logic sel);
        logic rs, ri, rl;
        rs = shot && !p_shot;
        ri = inc && !p_inc;
        rl = sel && !p_sel;
        p_shot = shot; p_inc = inc; p_sel = sel;
        if (rs) begin
            m_st = 1;
            m_s  = 0;
        end else if (m_st != 0 && !shot) begin
            m_st = 0;
        end else if (m_st == 0) begin
            if (tick) begin
                m_s = m_s + 1;
                if (m_s == 60) begin
                    m_s = 0;
                    m_m = m_m + 1;
                    if (m_m == 60) begin
                        m_m = 0;
                        model_hour_inc();
                    end
                end
            end
        end else if (m_st == 1) begin
            if (rl) m_st = 2;
            else if (ri) model_hour_inc();
        end else begin
            if (rl) m_st = 0;
            else if (ri) m_m = (m_m + 1) % 60;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic shot, input logic tick, input logic inc, input logic sel);
        @(negedge clk);
        bus.Shot = shot; bus.Tick = tick; bus.Inc = inc; bus.Sel = sel;
        model_step(shot, tick, inc, sel);
        exp_q.push_back({5'(m_h), 6'(m_m), 6'(m_s), 2'(m_st), (m_st != 0), m_pm});
        @(posedge clk);
        #2;
    endtask

    task automatic inc_pulse(input logic shot);
        drive(shot, 1'b0, 1'b1, 1'b0);
        drive(shot, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic sel_pulse(input logic shot);
        drive(shot, 1'b0, 1'b0, 1'b1);
        drive(shot, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.Shot = 1'b0; bus.Tick = 1'b0; bus.Inc = 1'b0; bus.Sel = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    // Monitor: every modelled edge has one expected entry; compare it just after the edge.
    always @(posedge clk) begin
        logic [W-1:0] exp_v, act_v;
        #1;
        if (exp_q.size() != 0) begin
            exp_v = exp_q.pop_front();
            act_v = {bus.Hours, bus.Minutes, bus.Seconds, bus.Field, bus.Set_Mode, bus.PM};
            n_cmp++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL scoreboard @%0t act=%0d:%0d:%0d f=%0d sm=%0d pm=%0d exp=%0d:%0d:%0d f=%0d sm=%0d pm=%0d",
                         $time, act_v[20:16], act_v[15:10], act_v[9:4], act_v[3:2], act_v[1], act_v[0],
                         exp_v[20:16], exp_v[15:10], exp_v[9:4], exp_v[3:2], exp_v[1], exp_v[0]);
            end
        end
    end

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.Shot = 1'b0; bus.Tick = 1'b0; bus.Inc = 1'b0; bus.Sel = 1'b0;
        reset = 1'b0;
        model_reset();
        #3;
        n_cmp++;
        if ({bus.Hours, bus.Minutes, bus.Seconds} !== {5'(RST_H), 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL reset_time act=%0d:%0d:%0d exp=%0d:0:0", bus.Hours, bus.Minutes, bus.Seconds, RST_H);
        end
        n_cmp++;
        if ({bus.Field, bus.Set_Mode} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_mode act=f%0d sm%0d exp=f0 sm0", bus.Field, bus.Set_Mode);
        end
        n_cmp++;
        if (bus.PM !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pm act=%0d exp=0", bus.PM);
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_count_minute();
        do_reset();
        for (int i = 0; i < 60; i++) begin
            // Idle gaps carry random Inc/Sel presses, which RUN must ignore.
            repeat ($urandom_range(0, 2))
                drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            drive(1'b0, 1'b1, 1'b0, 1'b0);
        end
        n_cmp++;
        if ({bus.Hours, bus.Minutes, bus.Seconds} !== {5'(RST_H), 6'd1, 6'd0}) begin
            n_fail++;
            $display("FAIL count_minute act=%0d:%0d:%0d exp=%0d:1:0", bus.Hours, bus.Minutes, bus.Seconds, RST_H);
        end
        n_cmp++;
        if (bus.Field !== 2'b00) begin
            n_fail++;
            $display("FAIL count_minute_field act=%0d exp=0", bus.Field);
        end
    endtask

    task automatic test_rollover();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < N_HINC; i++) inc_pulse(1'b1);
        sel_pulse(1'b1);
        for (int i = 0; i < 59; i++) inc_pulse(1'b1);
        sel_pulse(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (59) drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Hours, bus.Minutes, bus.Seconds, bus.PM} !== {5'(PRE_H), 6'd59, 6'd59, 1'b0}) begin
            n_fail++;
            $display("FAIL preload act=%0d:%0d:%0d pm%0d exp=%0d:59:59 pm0", bus.Hours, bus.Minutes, bus.Seconds, bus.PM, PRE_H);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Hours, bus.Minutes, bus.Seconds} !== {5'(ROLL_H), 6'd0, 6'd0}) begin
            n_fail++;
            $display("FAIL rollover act=%0d:%0d:%0d exp=%0d:0:0", bus.Hours, bus.Minutes, bus.Seconds, ROLL_H);
        end
        n_cmp++;
        if (bus.PM !== 1'(ROLL_PM)) begin
            n_fail++;
            $display("FAIL rollover_pm act=%0d exp=%0d", bus.PM, ROLL_PM);
        end
    endtask

    task automatic test_set_sequence();
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) inc_pulse(1'b1);
        sel_pulse(1'b1);
        for (int i = 0; i < 20; i++) inc_pulse(1'b1);
        sel_pulse(1'b1);
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (30) drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Hours, bus.Minutes, bus.Seconds} !== {5'd10, 6'd20, 6'd30}) begin
            n_fail++;
            $display("FAIL set_start act=%0d:%0d:%0d exp=10:20:30", bus.Hours, bus.Minutes, bus.Seconds);
        end
        // Shot rises together with a Tick: only the entry takes effect.
        drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Field, bus.Set_Mode, bus.Hours, bus.Minutes, bus.Seconds} !== {2'b01, 1'b1, 5'd10, 6'd20, 6'd0}) begin
            n_fail++;
            $display("FAIL set_entry act=f%0d sm%0d %0d:%0d:%0d exp=f1 sm1 10:20:0",
                     bus.Field, bus.Set_Mode, bus.Hours, bus.Minutes, bus.Seconds);
        end
        repeat (3) inc_pulse(1'b1);
        n_cmp++;
        if (bus.Hours !== 5'(SET_EXP_H)) begin
            n_fail++;
            $display("FAIL set_hour_inc act=%0d exp=%0d", bus.Hours, SET_EXP_H);
        end
        sel_pulse(1'b1);
        n_cmp++;
        if ({bus.Field, bus.Set_Mode} !== {2'b10, 1'b1}) begin
            n_fail++;
            $display("FAIL set_to_min act=f%0d sm%0d exp=f2 sm1", bus.Field, bus.Set_Mode);
        end
        for (int i = 0; i < 39; i++) inc_pulse(1'b1);
        inc_pulse(1'b1);
        n_cmp++;
        if ({bus.Hours, bus.Minutes} !== {5'(SET_EXP_H), 6'd0}) begin
            n_fail++;
            $display("FAIL set_min_wrap act=%0d:%0d exp=%0d:0", bus.Hours, bus.Minutes, SET_EXP_H);
        end
        sel_pulse(1'b1);
        n_cmp++;
        if ({bus.Field, bus.Set_Mode} !== 3'b000) begin
            n_fail++;
            $display("FAIL set_to_run act=f%0d sm%0d exp=f0 sm0", bus.Field, bus.Set_Mode);
        end
    endtask

    task automatic test_set_min_hold();
        int h0;
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        h0 = m_h;
        // Shot rises with Inc and Sel: entry only, Inc and Sel dropped.
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({bus.Field, bus.Hours} !== {2'b01, 5'(h0)}) begin
            n_fail++;
            $display("FAIL entry_with_inc_sel act=f%0d h%0d exp=f1 h%0d", bus.Field, bus.Hours, h0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        sel_pulse(1'b1);
        repeat (100) drive(1'b1, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Field, bus.Seconds} !== {2'b10, 6'd0}) begin
            n_fail++;
            $display("FAIL min_hold act=f%0d s%0d exp=f2 s0", bus.Field, bus.Seconds);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Field, bus.Set_Mode, bus.Seconds} !== {2'b00, 1'b0, 6'd0}) begin
            n_fail++;
            $display("FAIL shot_drop act=f%0d sm%0d s%0d exp=f0 sm0 s0", bus.Field, bus.Set_Mode, bus.Seconds);
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if (bus.Seconds !== 6'd1) begin
            n_fail++;
            $display("FAIL count_resume act=%0d exp=1", bus.Seconds);
        end
    endtask

    task automatic test_inc_sel_same();
        int h0;
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        h0 = m_h;
        drive(1'b1, 1'b0, 1'b1, 1'b1);
        n_cmp++;
        if ({bus.Field, bus.Hours} !== {2'b10, 5'(h0)}) begin
            n_fail++;
            $display("FAIL inc_sel_same act=f%0d h%0d exp=f2 h%0d", bus.Field, bus.Hours, h0);
        end
    endtask

    task automatic test_reset_mid_edit();
        drive(1'b1, 1'b0, 1'b0, 1'b0);
        inc_pulse(1'b1);
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        bus.Shot = 1'b0; bus.Tick = 1'b0; bus.Inc = 1'b0; bus.Sel = 1'b0;
        reset = 1'b0;
        model_reset();
        #1;
        n_cmp++;
        if ({bus.Field, bus.Set_Mode} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_reset_mode act=f%0d sm%0d exp=f0 sm0", bus.Field, bus.Set_Mode);
        end
        n_cmp++;
        if ({bus.Hours, bus.Minutes, bus.Seconds, bus.PM} !== {5'(RST_H), 6'd0, 6'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset_time act=%0d:%0d:%0d pm%0d exp=%0d:0:0 pm0",
                     bus.Hours, bus.Minutes, bus.Seconds, bus.PM, RST_H);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        n_cmp++;
        if ({bus.Field, bus.Seconds} !== {2'b00, 6'd1}) begin
            n_fail++;
            $display("FAIL after_release act=f%0d s%0d exp=f0 s1", bus.Field, bus.Seconds);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        model_reset();
        test_reset();
        test_count_minute();
        test_rollover();
        test_set_sequence();
        test_set_min_hold();
        test_inc_sel_same();
        test_reset_mid_edit();
        test_random();
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/set_clock_timekeeper.md
SET_CLOCK_TIMEKEEPER -- requirements
Module: set_clock_timekeeper

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Shot  input  1  level from the set-clock control; high = set enable.
REQ-005 Tick  input  1  one-cycle 1 Hz enable strobe.
REQ-006 Inc  input  1  synchronous, debounced increment button level.
REQ-007 Sel  input  1  synchronous, debounced field-select button level.
REQ-008 Hours  output  5  hour count.
REQ-009 Minutes  output  6  minute count, 0..59.
REQ-010 Seconds  output  6  second count, 0..59.
REQ-011 Field  output  2  edited field: 00 none (RUN), 01 hours, 10 minutes.
REQ-012 Set_Mode  output  1  high in any set state.
REQ-013 PM  output  1  afternoon flag; constant 0 unless CLOCK_12H_EN.

Function
REQ-014 The block SHALL register Shot, Inc and Sel once each and detect rising edges as current-high AND registered-low.
REQ-015 The FSM SHALL have three states: RUN, SET_HOUR, SET_MIN.
REQ-016 Shot rising edge in any state SHALL go to SET_HOUR and clear Seconds to 0.
REQ-017 Sel rising edge SHALL step SET_HOUR->SET_MIN->RUN; in RUN it SHALL be ignored.
REQ-018 Shot low in any set state SHALL force RUN on the next edge.
REQ-019 In RUN, a Tick SHALL advance Seconds; 59 wraps to 0 and carries to Minutes; Minutes 59 wraps to 0 and carries to Hours; Hours 23 wraps to 0.
REQ-020 In set states, Tick SHALL be ignored and Seconds held.
REQ-021 Inc rising edge SHALL increment only the selected field, wrapping with no carry (Minutes 59->0, Hours 23->0).
REQ-022 Inc and Sel edges in the same cycle: Sel SHALL be applied and Inc dropped.
REQ-023 Shot rising edge coinciding with Tick, Inc or Sel: only the SET_HOUR entry SHALL take effect.
REQ-024 All outputs SHALL be registered or decoded from registered state; any action SHALL be visible after the clock edge that samples its qualifying input.
REQ-025 Field/Set_Mode SHALL decode: RUN 00/0, SET_HOUR 01/1, SET_MIN 10/1.

Reset
REQ-026 Reset low SHALL asynchronously force RUN, Seconds=0, Minutes=0, Hours=0 (12 when CLOCK_12H_EN), PM=0, and all edge registers to 0.
REQ-027 Reset asserted mid-edit SHALL discard the edit; after release the block SHALL start in RUN.

Configuration
REQ-028 Macro CLOCK_12H_EN defined: Hours range 1..12, 12->1 wraps, 11->12 toggles PM (on both carry and Inc), reset value 12 with PM=0.
REQ-029 CLOCK_12H_EN undefined: Hours range 0..23, PM tied 0, and no 12-hour logic SHALL be compiled.

Structure
REQ-030 Package set_clock_pkg SHALL hold the state encoding, Field encodings, and limit constants SEC_MAX=59, MIN_MAX=59, HOUR_MAX_24=23, HOUR_MAX_12=12.
REQ-031 Rising-edge detection SHALL be one sub-module, edge_detect (clk, reset, in, rise), instantiated three times.

Verification
REQ-032 Reset, then 60 Ticks -> Seconds=0, Minutes=1, Hours=0, Field=00.
REQ-033 Preload 23:59:59, one Tick -> 00:00:00 (12H build: 11:59:59 PM=0 -> 12:00:00 PM=1).
REQ-034 Shot rises at 10:20:30 -> SET_HOUR, Seconds=0; 3 Inc pulses -> Hours=13; Sel -> SET_MIN; Inc at 59 -> Minutes=0, Hours unchanged; Sel -> RUN.
REQ-035 In SET_MIN, Ticks every cycle for 100 cycles -> Seconds stays 0; Shot drop -> RUN on the next edge, counting resumes.
REQ-036 Inc and Sel rise in the same cycle in SET_HOUR -> SET_MIN, Hours unchanged.
REQ-037 Reset asserted in SET_MIN mid-sequence -> immediate RUN, 00:00:00 (12H build: 12:00:00 PM=0), Field=00.
